// File: rtl/ahb_apb_bridge_ctrl_if.sv
// AHB/APB bus bundle for the AHB-to-APB bridge controller.
// slave  : the bridge's view (AHB slave, APB master side outputs).
// master : the view of whatever drives the AHB side and returns Prdata.
interface ahb_apb_bridge_ctrl_if;
    // AHB side
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    // APB side
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pwrite;
    logic        Penable;
    logic [3:0]  Pselx;
    logic [31:0] Prdata;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
        output Hreadyout, Hresp, Hrdata, Paddr, Pwdata, Pwrite, Penable, Pselx
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
        input  Hreadyout, Hresp, Hrdata, Paddr, Pwdata, Pwrite, Penable, Pselx
    );
endinterface

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-to-APB bridge controller.
// Accepts one AHB transfer at a time from IDLE, decodes it into one of four
// APB selects and runs a SETUP/ENABLE APB cycle. Writes spend one extra
// cycle (WWAIT) collecting Hwdata from the AHB data phase.
// Optional feature: define BRIDGE_ERR_RESP_EN to answer out-of-window
// transfers with a two-cycle AHB ERROR response; otherwise they are ignored.
module ahb_apb_bridge_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] SLV_SPAN  = 32'h0400_0000
) (
    input logic                  clock,
    input logic                  Presetn,
    ahb_apb_bridge_ctrl_if.slave bus
);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef BRIDGE_ERR_RESP_EN
    localparam logic [1:0] RESP_ERROR = 2'b01;
`endif

    // Window boundaries, 34 bits wide so 4*SLV_SPAN cannot overflow.
    localparam logic [33:0] SPAN1 = {2'b00, SLV_SPAN};
    localparam logic [33:0] SPAN2 = SPAN1 << 1;
    localparam logic [33:0] SPAN3 = SPAN1 + SPAN2;
    localparam logic [33:0] SPAN4 = SPAN1 << 2;

`ifdef BRIDGE_ERR_RESP_EN
    typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ENABLE, ERR1, ERR2} state_t;
`else
    typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ENABLE} state_t;
`endif

    state_t      state;
    logic [3:0]  sel_q;       // select held while a write waits for its data
    logic [33:0] offs;
    logic [3:0]  dec_sel;
    logic        in_range;
    logic        htrans_act;
    logic        xfer_valid;

    // Address decode: offset below BASE wraps into the top bits, so it is
    // caught by the same upper-bound compare as addresses past the window.
    always_comb begin
        offs    = {2'b00, bus.Haddr} - {2'b00, BASE_ADDR};
        dec_sel = 4'b0000;
        if (offs < SPAN1)      dec_sel = 4'b0001;
        else if (offs < SPAN2) dec_sel = 4'b0010;
        else if (offs < SPAN3) dec_sel = 4'b0100;
        else if (offs < SPAN4) dec_sel = 4'b1000;
    end

    // A transfer is only taken when the master drives NONSEQ/SEQ and the
    // previous data phase is finishing on this edge.
    always_comb begin
        in_range   = (dec_sel != 4'b0000);
        htrans_act = (bus.Htrans == 2'b10) || (bus.Htrans == 2'b11);
        xfer_valid = bus.Hreadyin && htrans_act && bus.Hreadyout;
    end

    // Bridge FSM; every bus output is a register updated on the transition.
    always_ff @(posedge clock or negedge Presetn) begin
        if (!Presetn) begin
            state         <= IDLE;
            sel_q         <= 4'b0000;
            bus.Hreadyout <= 1'b1;
            bus.Hresp     <= RESP_OKAY;
            bus.Hrdata    <= 32'h0;
            bus.Paddr     <= 32'h0;
            bus.Pwdata    <= 32'h0;
            bus.Pwrite    <= 1'b0;
            bus.Penable   <= 1'b0;
            bus.Pselx     <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    bus.Hreadyout <= 1'b1;
                    bus.Hresp     <= RESP_OKAY;
                    bus.Pselx     <= 4'b0000;
                    bus.Penable   <= 1'b0;
                    if (xfer_valid && in_range) begin
                        bus.Paddr     <= bus.Haddr;
                        bus.Pwrite    <= bus.Hwrite;
                        sel_q         <= dec_sel;
                        bus.Hreadyout <= 1'b0;
                        if (bus.Hwrite) begin
                            state <= WWAIT;
                        end else begin
                            // Reads go straight to SETUP, so present the select now.
                            bus.Pselx <= dec_sel;
                            state     <= SETUP;
                        end
                    end
`ifdef BRIDGE_ERR_RESP_EN
                    else if (xfer_valid) begin
                        bus.Hresp     <= RESP_ERROR;
                        bus.Hreadyout <= 1'b0;
                        state         <= ERR1;
                    end
`endif
                end
                WWAIT: begin
                    // Hwdata belongs to the data phase, valid in this cycle.
                    bus.Pwdata <= bus.Hwdata;
                    bus.Pselx  <= sel_q;
                    state      <= SETUP;
                end
                SETUP: begin
                    bus.Penable <= 1'b1;
                    state       <= ENABLE;
                end
                ENABLE: begin
                    if (!bus.Pwrite) bus.Hrdata <= bus.Prdata;
                    bus.Pselx     <= 4'b0000;
                    bus.Penable   <= 1'b0;
                    bus.Hreadyout <= 1'b1;
                    state         <= IDLE;
                end
`ifdef BRIDGE_ERR_RESP_EN
                ERR1: begin
                    // Second half of the two-cycle ERROR response.
                    bus.Hreadyout <= 1'b1;
                    state         <= ERR2;
                end
                ERR2: begin
                    bus.Hresp <= RESP_OKAY;
                    state     <= IDLE;
                end
`endif
                default: begin
                    bus.Hreadyout <= 1'b1;
                    bus.Hresp     <= RESP_OKAY;
                    bus.Pselx     <= 4'b0000;
                    bus.Penable   <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Self-checking bench for ahb_apb_bridge_ctrl: directed scenarios plus
// randomized transfers checked against a transaction-level latency model.
module tb_ahb_apb_bridge_ctrl;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SPAN = 32'h0400_0000;

    logic clock   = 1'b0;
    logic Presetn = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    // Architectural state the bridge must retain between transfers.
    logic [31:0] hrd_exp    = 32'h0;
    logic [31:0] paddr_exp  = 32'h0;
    logic [31:0] pwdata_exp = 32'h0;
    logic        pwrite_exp = 1'b0;

    logic [31:0] edges [8];

    ahb_apb_bridge_ctrl_if bus();

    ahb_apb_bridge_ctrl #(.BASE_ADDR(BASE), .SLV_SPAN(SPAN)) dut (
        .clock   (clock),
        .Presetn (Presetn),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference decode: which 4-slot window (if any) an address falls in.
    function automatic logic [3:0] ref_sel(input logic [31:0] a);
        longint off;
        longint sp;
        logic [3:0] one;
        one = 4'b0001;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        sp  = longint'({32'd0, SPAN});
        if (off < 0 || off >= 4 * sp) return 4'b0000;
        return one << (off / sp);
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_rdy"},    32'(bus.Hreadyout), 32'd1);
        chk({tag, "_resp"},   32'(bus.Hresp),     32'd0);
        chk({tag, "_sel"},    32'(bus.Pselx),     32'd0);
        chk({tag, "_pen"},    32'(bus.Penable),   32'd0);
        chk({tag, "_hrdata"}, bus.Hrdata,         hrd_exp);
        chk({tag, "_paddr"},  bus.Paddr,          paddr_exp);
        chk({tag, "_pwrite"}, 32'(bus.Pwrite),    32'(pwrite_exp));
        chk({tag, "_pwdata"}, bus.Pwdata,         pwdata_exp);
    endtask

    // Random AHB noise while the bridge is stalling; must all be ignored.
    task automatic scramble();
        bus.Htrans   = 2'($urandom);
        bus.Hreadyin = 1'($urandom);
        bus.Haddr    = $urandom;
        bus.Hwrite   = 1'($urandom);
        bus.Hwdata   = $urandom;
    endtask

    // Called at a negedge where Hreadyout=1; returns at the negedge of the
    // first ready cycle after the transfer, having checked every cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd);
        logic [3:0] sel;
        int waits;
        int ph;
        sel = ref_sel(addr);
        bus.Htrans   = $urandom_range(0, 1) ? 2'b10 : 2'b11;
        bus.Hreadyin = 1'b1;
        bus.Hwrite   = wr;
        bus.Haddr    = addr;
        bus.Hwdata   = $urandom;
        @(negedge clock);
        scramble();
        bus.Hwdata = wd;
        if (sel == 4'b0000) begin
`ifdef BRIDGE_ERR_RESP_EN
            chk("err1_rdy",  32'(bus.Hreadyout), 32'd0);
            chk("err1_resp", 32'(bus.Hresp),     32'd1);
            chk("err1_sel",  32'(bus.Pselx),     32'd0);
            bus.Htrans = 2'b00;
            @(negedge clock);
            chk("err2_rdy",  32'(bus.Hreadyout), 32'd1);
            chk("err2_resp", 32'(bus.Hresp),     32'd1);
            chk("err2_sel",  32'(bus.Pselx),     32'd0);
            chk("err2_pen",  32'(bus.Penable),   32'd0);
            bus.Htrans = 2'b00;
            @(negedge clock);
            check_idle("err_done");
`else
            check_idle("oor_ignored");
`endif
        end else begin
            waits = wr ? 3 : 2;
            for (int k = 0; k < waits; k++) begin
                ph = k - (waits - 2);   // -1 data wait, 0 APB setup, 1 APB enable
                chk("wait_rdy",  32'(bus.Hreadyout), 32'd0);
                chk("wait_resp", 32'(bus.Hresp),     32'd0);
                if (ph < 0) begin
                    chk("wwait_sel", 32'(bus.Pselx),   32'd0);
                    chk("wwait_pen", 32'(bus.Penable), 32'd0);
                end else begin
                    chk("apb_sel",    32'(bus.Pselx),   32'(sel));
                    chk("apb_pen",    32'(bus.Penable), (ph == 1) ? 32'd1 : 32'd0);
                    chk("apb_paddr",  bus.Paddr,        addr);
                    chk("apb_pwrite", 32'(bus.Pwrite),  32'(wr));
                    chk("apb_pwdata", bus.Pwdata,       wr ? wd : pwdata_exp);
                end
                bus.Prdata = (ph == 1) ? rd : $urandom;
                @(negedge clock);
                scramble();
            end
            paddr_exp  = addr;
            pwrite_exp = wr;
            if (wr) pwdata_exp = wd;
            else    hrd_exp    = rd;
            check_idle("done");
        end
    endtask

    task automatic idle_cycle();
        if ($urandom_range(0, 1) != 0) begin
            bus.Hreadyin = 1'b1;
            bus.Htrans   = 2'($urandom_range(0, 1));
        end else begin
            bus.Hreadyin = 1'b0;
            bus.Htrans   = 2'b10;
        end
        bus.Haddr  = BASE + $urandom_range(0, 32'h0FFF_FFFF);
        bus.Hwrite = 1'($urandom);
        @(negedge clock);
        check_idle("idle");
    endtask

    // Reset dropped asynchronously while a read sits in ENABLE.
    task automatic reset_during_enable(input logic [31:0] addr);
        bus.Htrans   = 2'b10;
        bus.Hreadyin = 1'b1;
        bus.Hwrite   = 1'b0;
        bus.Haddr    = addr;
        @(negedge clock);
        scramble();
        @(negedge clock);
        chk("pre_rst_pen", 32'(bus.Penable), 32'd1);
        #2 Presetn = 1'b0;
        #1;
        hrd_exp    = 32'h0;
        paddr_exp  = 32'h0;
        pwdata_exp = 32'h0;
        pwrite_exp = 1'b0;
        check_idle("async_rst");
        @(negedge clock);
        bus.Htrans   = 2'b00;
        bus.Hreadyin = 1'b1;
        Presetn      = 1'b1;
        idle_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        edges[0] = BASE - 32'd4;
        edges[1] = BASE + 32'h1000_0000;
        edges[2] = BASE + SPAN - 32'd4;
        edges[3] = BASE + SPAN;
        edges[4] = BASE + 32'h0C00_0000;
        edges[5] = BASE + 32'h0FFF_FFFC;
        edges[6] = 32'h0000_0000;
        edges[7] = 32'hFFFF_FFFC;

        bus.Hwrite   = 1'b0;
        bus.Hreadyin = 1'b1;
        bus.Htrans   = 2'b00;
        bus.Haddr    = 32'h0;
        bus.Hwdata   = 32'h0;
        bus.Prdata   = 32'h0;

        repeat (2) @(negedge clock);
        check_idle("reset");
        Presetn = 1'b1;
        idle_cycle();

        // Directed scenarios.
        xfer(1'b0, 32'h8400_0010, 32'h0, 32'hDEAD_BEEF);
        idle_cycle();
        xfer(1'b1, 32'h8C00_0004, 32'h1234_5678, 32'h5555_AAAA);
        idle_cycle();
        xfer(1'b0, 32'h8000_0000, 32'h0, 32'h0BAD_F00D);
        xfer(1'b1, 32'h8800_0000, 32'hCAFE_0001, 32'h0);
        idle_cycle();
        reset_during_enable(32'h8400_0020);
        xfer(1'b0, 32'h8000_0040, 32'h0, 32'hA5A5_5A5A);
        idle_cycle();
        xfer(1'b0, 32'h9000_0000, 32'h0, 32'h1111_2222);
        idle_cycle();

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 7)
                addr = (BASE + $urandom_range(0, 32'h0FFF_FFFF)) & 32'hFFFF_FFFC;
            else if ($urandom_range(0, 3) == 0)
                addr = $urandom;
            else
                addr = edges[$urandom_range(0, 7)];
            xfer(1'($urandom), addr, $urandom, $urandom);
            if ($urandom_range(0, 1) != 0) begin
                repeat ($urandom_range(1, 3)) idle_cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
